// File: rtl/bram_read_scheduler_if.sv
// rtl/bram_read_scheduler_if.sv - read request/response handshakes of the two frame buffer requesters
interface bram_read_scheduler_if #(
   parameter int AW = 19
);
   logic          rq0_valid;
   logic [AW-1:0] rq0_addr;
   logic          rq0_ready;
   logic          rq1_valid;
   logic [AW-1:0] rq1_addr;
   logic          rq1_ready;
   logic          rs0_valid;
   logic          rs0_data;
   logic          rs0_err;
   logic [7:0]    rs0_frame;
   logic          rs1_valid;
   logic          rs1_data;
   logic          rs1_err;
   logic [7:0]    rs1_frame;

   modport master (
      output rq0_valid, rq0_addr, rq1_valid, rq1_addr,
      input  rq0_ready, rq1_ready,
      input  rs0_valid, rs0_data, rs0_err, rs0_frame,
      input  rs1_valid, rs1_data, rs1_err, rs1_frame
   );

   modport slave (
      input  rq0_valid, rq0_addr, rq1_valid, rq1_addr,
      output rq0_ready, rq1_ready,
      output rs0_valid, rs0_data, rs0_err, rs0_frame,
      output rs1_valid, rs1_data, rs1_err, rs1_frame
   );
endinterface

// File: rtl/bram_read_scheduler.sv
// rtl/bram_read_scheduler.sv - frame buffer capture sequencing and round-robin read port arbitration (optional watchdog: CAPTURE_TIMEOUT_EN)
module bram_read_scheduler #(
   parameter int IMG_WIDTH      = 640,
   parameter int IMG_HEIGHT     = 480,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int AW             = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          capture_req,
   output logic          frame_ready,
   output logic [7:0]    frame_id,
   output logic          cap_timeout,
   output logic          bram_capture_trigger,
   input  logic          bram_capture_complete,
   input  logic          bram_valid_to_read,
   output logic [AW-1:0] bram_read_addr,
   input  logic          bram_read_data,
   bram_read_scheduler_if.slave rd
);

   localparam int            NPIX_I = IMG_WIDTH * IMG_HEIGHT;
   localparam logic [AW:0]   NPIX   = NPIX_I[AW:0];

   typedef enum logic [2:0] {IDLE, ARM, WAIT_CAP, SERVE, DRAIN} state_t;

   state_t        state_q, state_d;
   logic          pend_q, pend_d;
   logic          rr_q;
   logic [7:0]    frame_q;
   logic [AW-1:0] last_addr_q;
   logic          resp_valid_q, resp_id_q, resp_err_q;
   logic [7:0]    resp_frame_q;
   logic          serving, gnt0, gnt1, gnt_err, timeout;
   logic [AW-1:0] sel_addr;

   // A zero-cycle watchdog limit is meaningless; reject it at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef CAPTURE_TIMEOUT_EN
   logic [31:0] to_cnt_q;

   // Watchdog counts cycles spent in WAIT_CAP and clears in every other state.
   always_ff @(posedge clk) begin
      if (!rst_n || state_q != WAIT_CAP) to_cnt_q <= '0;
      else                              to_cnt_q <= to_cnt_q + 32'd1;
   end

   assign timeout = rst_n && (state_q == WAIT_CAP) && !bram_capture_complete &&
                    (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Round-robin grant, only while a valid frame is being served; out-of-range addresses still get a slot.
   always_comb begin
      serving  = rst_n && (state_q == SERVE) && bram_valid_to_read;
      gnt0     = serving && rd.rq0_valid && (!rd.rq1_valid || !rr_q);
      gnt1     = serving && rd.rq1_valid && (!rd.rq0_valid ||  rr_q);
      sel_addr = gnt1 ? rd.rq1_addr : rd.rq0_addr;
      gnt_err  = ({1'b0, sel_addr} >= NPIX);
   end

   // Capture sequencing; requests arriving outside IDLE/SERVE collapse into one pending flag.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (capture_req) state_d = ARM;
         end
         ARM: begin
            state_d = WAIT_CAP;
            if (capture_req) pend_d = 1'b1;
         end
         WAIT_CAP: begin
            if (capture_req) pend_d = 1'b1;
            if (bram_capture_complete) begin
               state_d = SERVE;
            end else if (timeout) begin
               state_d = IDLE;
               pend_d  = 1'b0;
            end
         end
         SERVE: begin
            if (capture_req || pend_q) begin
               state_d = DRAIN;
               pend_d  = 1'b0;
            end
         end
         DRAIN: begin
            state_d = ARM;
            if (capture_req) pend_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, frame counter, arbitration pointer and the one-deep response pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pend_q       <= 1'b0;
         rr_q         <= 1'b0;
         frame_q      <= 8'd0;
         last_addr_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_frame_q <= 8'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (state_q == WAIT_CAP && bram_capture_complete) frame_q <= frame_q + 8'd1;
         if (gnt0)      rr_q <= 1'b1;
         else if (gnt1) rr_q <= 1'b0;
         if (gnt0 || gnt1) last_addr_q <= gnt_err ? '0 : sel_addr;
         resp_valid_q <= gnt0 || gnt1;
         resp_id_q    <= gnt1;
         resp_err_q   <= gnt_err;
         resp_frame_q <= frame_q;
      end
   end

   // Outputs, forced to zero while reset is asserted; read data passes straight through from the buffer.
   always_comb begin
      frame_ready          = serving;
      frame_id             = rst_n ? frame_q : 8'd0;
      cap_timeout          = timeout;
      bram_capture_trigger = rst_n && (state_q == ARM);
      bram_read_addr       = '0;
      if (rst_n) bram_read_addr = (gnt0 || gnt1) ? (gnt_err ? '0 : sel_addr) : last_addr_q;
      rd.rq0_ready = gnt0;
      rd.rq1_ready = gnt1;
      rd.rs0_valid = rst_n && resp_valid_q && !resp_id_q;
      rd.rs1_valid = rst_n && resp_valid_q &&  resp_id_q;
      rd.rs0_data  = rd.rs0_valid && !resp_err_q && bram_read_data;
      rd.rs1_data  = rd.rs1_valid && !resp_err_q && bram_read_data;
      rd.rs0_err   = rd.rs0_valid && resp_err_q;
      rd.rs1_err   = rd.rs1_valid && resp_err_q;
      rd.rs0_frame = rd.rs0_valid ? resp_frame_q : 8'd0;
      rd.rs1_frame = rd.rs1_valid ? resp_frame_q : 8'd0;
   end

endmodule
